ref_cline_req_sequencer: RTL and testbench

- Accepts one reference-block descriptor (pixel start x/y plus block width and height, each minus one).
- Computes the range of cache lines the block covers and issues one request per cache line, in raster order, over a valid/ready handshake to the cache tag-lookup stage.
- Generalises the combinational cache-line span count: any span width, registered outputs, backpressure, first/last markers.
- Sits between the prediction reference-fetch front end and the cache tag/miss logic.

---
 rtl/ref_cline_req_sequencer_pkg.sv | 34 +++
 rtl/ref_cline_req_sequencer_span.sv | 33 +++
 rtl/ref_cline_req_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_ref_cline_req_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ref_cline_req_sequencer_pkg.sv
// ref_cline_req_sequencer_pkg
//   Shared cache geometry, coordinate widths, derived line-index and span
//   widths, and the sequencer FSM state encoding.
package ref_cline_req_sequencer_pkg;

  localparam int unsigned CFG_C_L_H_SIZE = 3;   // 8-pixel-wide cache lines
  localparam int unsigned CFG_C_L_V_SIZE = 2;   // 4-row-tall cache lines
  localparam int unsigned CFG_DIM_WDTH   = 4;
  localparam int unsigned CFG_X_WDTH     = 12;
  localparam int unsigned CFG_Y_WDTH     = 12;

  localparam int unsigned CFG_CL_X_WDTH  = CFG_X_WDTH - CFG_C_L_H_SIZE;
  localparam int unsigned CFG_CL_Y_WDTH  = CFG_Y_WDTH - CFG_C_L_V_SIZE;

  // Bits needed for a per-axis line-span count: the largest delta is
  // ceil((2^dim_w - 1) / 2^ls), and the field must also hold that value + 1.
  function automatic int unsigned span_bits(input int unsigned dim_w,
                                            input int unsigned ls);
    int unsigned max_delta;
    max_delta = (((1 << dim_w) - 1) + ((1 << ls) - 1)) >> ls;
    return $clog2(max_delta + 2);
  endfunction

  localparam int unsigned CFG_SPAN_X = span_bits(CFG_DIM_WDTH, CFG_C_L_H_SIZE);
  localparam int unsigned CFG_SPAN_Y = span_bits(CFG_DIM_WDTH, CFG_C_L_V_SIZE);
  localparam int unsigned CFG_SPAN_WDTH =
    (CFG_SPAN_X > CFG_SPAN_Y) ? CFG_SPAN_X : CFG_SPAN_Y;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } seq_state_e;

endpackage

// File: rtl/ref_cline_req_sequencer_span.sv
// cline_span_calc
//   Combinational per-axis cache-line span: base line index of the block
//   start and the number of lines covered minus one.
//   Ports:
//     i_start  block start pixel coordinate
//     i_dim    block dimension minus one
//     o_base   line index containing i_start
//     o_delta  lines spanned minus one
module cline_span_calc #(
  parameter int unsigned COORD_WDTH = 12,
  parameter int unsigned DIM_WDTH   = 4,
  parameter int unsigned LINE_SIZE  = 3,
  parameter int unsigned SPAN_WDTH  = 3
) (
  input  logic [COORD_WDTH-1:0]           i_start,
  input  logic [DIM_WDTH-1:0]             i_dim,
  output logic [COORD_WDTH-LINE_SIZE-1:0] o_base,
  output logic [SPAN_WDTH-1:0]            o_delta
);

  localparam int unsigned LINE_W = COORD_WDTH - LINE_SIZE;

  // End line index keeps the carry bit so a block crossing the top of the
  // coordinate space still yields the correct (wrapped) line difference.
  logic [LINE_W:0] w_end_line;
  logic [LINE_W:0] w_diff;

  assign o_base     = i_start[COORD_WDTH-1:LINE_SIZE];
  assign w_end_line = (LINE_W+1)'(({1'b0, i_start} + (COORD_WDTH+1)'(i_dim)) >> LINE_SIZE);
  assign w_diff     = w_end_line - {1'b0, o_base};
  assign o_delta    = SPAN_WDTH'(w_diff);

endmodule

// File: rtl/ref_cline_req_sequencer.sv
// ref_cline_req_sequencer
//   Takes one reference-block descriptor and issues one cache-line request
//   per covered line, raster order, over a valid/ready handshake.
//   Optional statistics counters are enabled by defining CLINE_STAT_EN.
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     blk_valid_in / blk_ready_out    descriptor handshake
//     start_x_in, start_y_in          block top-left pixel
//     rf_blk_wdt_in, rf_blk_hgt_in    block width/height minus one
//     cline_valid_out / cline_ready_in request handshake
//     cline_x_out, cline_y_out        cache-line column/row index
//     cline_first_out, cline_last_out first/last request of the block
//     delta_x_out, delta_y_out        lines spanned minus one, per block
//     stat_blk_cnt_out                blocks accepted (CLINE_STAT_EN)
//     stat_cline_cnt_out              requests handshaken (CLINE_STAT_EN)
module ref_cline_req_sequencer
  import ref_cline_req_sequencer_pkg::*;
#(
  parameter int unsigned C_L_H_SIZE = CFG_C_L_H_SIZE,
  parameter int unsigned C_L_V_SIZE = CFG_C_L_V_SIZE,
  parameter int unsigned DIM_WDTH   = CFG_DIM_WDTH,
  parameter int unsigned X_WDTH     = CFG_X_WDTH,
  parameter int unsigned Y_WDTH     = CFG_Y_WDTH,
  parameter int unsigned SPAN_WDTH  = CFG_SPAN_WDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         blk_valid_in,
  output logic                         blk_ready_out,
  input  logic [X_WDTH-1:0]            start_x_in,
  input  logic [Y_WDTH-1:0]            start_y_in,
  input  logic [DIM_WDTH-1:0]          rf_blk_wdt_in,
  input  logic [DIM_WDTH-1:0]          rf_blk_hgt_in,
  output logic                         cline_valid_out,
  input  logic                         cline_ready_in,
  output logic [X_WDTH-C_L_H_SIZE-1:0] cline_x_out,
  output logic [Y_WDTH-C_L_V_SIZE-1:0] cline_y_out,
  output logic                         cline_first_out,
  output logic                         cline_last_out,
  output logic [SPAN_WDTH-1:0]         delta_x_out,
  output logic [SPAN_WDTH-1:0]         delta_y_out
`ifdef CLINE_STAT_EN
  ,
  output logic [31:0]                  stat_blk_cnt_out,
  output logic [31:0]                  stat_cline_cnt_out
`endif
);

  localparam int unsigned LX_W = X_WDTH - C_L_H_SIZE;
  localparam int unsigned LY_W = Y_WDTH - C_L_V_SIZE;

  seq_state_e            r_state;
  seq_state_e            w_state_nxt;

  logic [LX_W-1:0]       w_base_x;
  logic [LY_W-1:0]       w_base_y;
  logic [SPAN_WDTH-1:0]  w_delta_x;
  logic [SPAN_WDTH-1:0]  w_delta_y;

  logic [LX_W-1:0]       r_base_x;
  logic [LY_W-1:0]       r_base_y;
  logic [SPAN_WDTH-1:0]  r_delta_x;
  logic [SPAN_WDTH-1:0]  r_delta_y;
  logic [SPAN_WDTH-1:0]  r_cnt_x;
  logic [SPAN_WDTH-1:0]  r_cnt_y;

  logic                  w_accept;
  logic                  w_fire;
  logic                  w_x_end;
  logic                  w_y_end;
  logic                  w_final;

  cline_span_calc #(
    .COORD_WDTH (X_WDTH),
    .DIM_WDTH   (DIM_WDTH),
    .LINE_SIZE  (C_L_H_SIZE),
    .SPAN_WDTH  (SPAN_WDTH)
  ) u_span_x (
    .i_start (start_x_in),
    .i_dim   (rf_blk_wdt_in),
    .o_base  (w_base_x),
    .o_delta (w_delta_x)
  );

  cline_span_calc #(
    .COORD_WDTH (Y_WDTH),
    .DIM_WDTH   (DIM_WDTH),
    .LINE_SIZE  (C_L_V_SIZE),
    .SPAN_WDTH  (SPAN_WDTH)
  ) u_span_y (
    .i_start (start_y_in),
    .i_dim   (rf_blk_hgt_in),
    .o_base  (w_base_y),
    .o_delta (w_delta_y)
  );

  assign w_x_end = (r_cnt_x == r_delta_x);
  assign w_y_end = (r_cnt_y == r_delta_y);
  assign w_final = w_x_end && w_y_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    blk_ready_out   = 1'b0;
    cline_valid_out = 1'b0;
    w_accept        = 1'b0;
    w_fire          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        blk_ready_out = 1'b1;
        if (blk_valid_in) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cline_valid_out = 1'b1;
        if (cline_ready_in) begin
          w_fire = 1'b1;
          if (w_final) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base_x  <= '0;
      r_base_y  <= '0;
      r_delta_x <= '0;
      r_delta_y <= '0;
      r_cnt_x   <= '0;
      r_cnt_y   <= '0;
    end else if (w_accept) begin
      r_base_x  <= w_base_x;
      r_base_y  <= w_base_y;
      r_delta_x <= w_delta_x;
      r_delta_y <= w_delta_y;
      r_cnt_x   <= '0;
      r_cnt_y   <= '0;
    end else if (w_fire) begin
      if (w_final) begin
        r_cnt_x <= '0;
        r_cnt_y <= '0;
      end else if (w_x_end) begin
        r_cnt_x <= '0;
        r_cnt_y <= r_cnt_y + 1'b1;
      end else begin
        r_cnt_x <= r_cnt_x + 1'b1;
      end
    end
  end

  // Outputs decode registers only, so they cannot move while the request
  // is stalled by cline_ready_in.
  assign cline_x_out     = r_base_x + LX_W'(r_cnt_x);
  assign cline_y_out     = r_base_y + LY_W'(r_cnt_y);
  assign cline_first_out = (r_state == ST_ISSUE) && (r_cnt_x == '0) && (r_cnt_y == '0);
  assign cline_last_out  = (r_state == ST_ISSUE) && w_final;
  assign delta_x_out     = r_delta_x;
  assign delta_y_out     = r_delta_y;

`ifdef CLINE_STAT_EN
  logic [31:0] r_stat_blk;
  logic [31:0] r_stat_cline;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_blk   <= '0;
      r_stat_cline <= '0;
    end else begin
      if (w_accept) r_stat_blk   <= r_stat_blk + 32'd1;
      if (w_fire)   r_stat_cline <= r_stat_cline + 32'd1;
    end
  end

  assign stat_blk_cnt_out   = r_stat_blk;
  assign stat_cline_cnt_out = r_stat_cline;
`endif

endmodule

// File: tb/tb_ref_cline_req_sequencer.sv
// Testbench for ref_cline_req_sequencer: directed descriptors, expected
// requests queued at issue time, monitor compares on each handshake.
module tb_ref_cline_req_sequencer;

  typedef struct packed {
    logic [8:0] x;
    logic [9:0] y;
    logic       first;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        blk_valid_in;
  logic        blk_ready_out;
  logic [11:0] start_x_in;
  logic [11:0] start_y_in;
  logic [3:0]  rf_blk_wdt_in;
  logic [3:0]  rf_blk_hgt_in;
  logic        cline_valid_out;
  logic        cline_ready_in;
  logic [8:0]  cline_x_out;
  logic [9:0]  cline_y_out;
  logic        cline_first_out;
  logic        cline_last_out;
  logic [2:0]  delta_x_out;
  logic [2:0]  delta_y_out;
`ifdef CLINE_STAT_EN
  logic [31:0] stat_blk_cnt_out;
  logic [31:0] stat_cline_cnt_out;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  bit   stall_pend = 1'b0;
  exp_t stall_val;

  ref_cline_req_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .blk_valid_in    (blk_valid_in),
    .blk_ready_out   (blk_ready_out),
    .start_x_in      (start_x_in),
    .start_y_in      (start_y_in),
    .rf_blk_wdt_in   (rf_blk_wdt_in),
    .rf_blk_hgt_in   (rf_blk_hgt_in),
    .cline_valid_out (cline_valid_out),
    .cline_ready_in  (cline_ready_in),
    .cline_x_out     (cline_x_out),
    .cline_y_out     (cline_y_out),
    .cline_first_out (cline_first_out),
    .cline_last_out  (cline_last_out),
    .delta_x_out     (delta_x_out),
    .delta_y_out     (delta_y_out)
`ifdef CLINE_STAT_EN
    ,
    .stat_blk_cnt_out   (stat_blk_cnt_out),
    .stat_cline_cnt_out (stat_cline_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compares on every handshake and checks stall stability.
  always @(negedge clk) begin
    exp_t cur;
    exp_t e;
    cur = '{x: cline_x_out, y: cline_y_out, first: cline_first_out, last: cline_last_out};
    if (!reset && stall_pend) begin
      n_cmp++;
      if (cur !== stall_val) begin
        n_bad++;
        $display("FAIL stall_stable: got x=%0d y=%0d f=%0b l=%0b, expected x=%0d y=%0d f=%0b l=%0b",
                 cur.x, cur.y, cur.first, cur.last,
                 stall_val.x, stall_val.y, stall_val.first, stall_val.last);
      end
    end
    stall_pend = 1'b0;
    if (!reset && cline_valid_out === 1'b1) begin
      if (cline_ready_in) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_req: got x=%0d y=%0d, expected no request", cur.x, cur.y);
        end else begin
          e = q.pop_front();
          n_cmp++;
          if (cur !== e) begin
            n_bad++;
            $display("FAIL req: got x=%0d y=%0d f=%0b l=%0b, expected x=%0d y=%0d f=%0b l=%0b",
                     cur.x, cur.y, cur.first, cur.last, e.x, e.y, e.first, e.last);
          end
        end
      end else begin
        stall_pend = 1'b1;
        stall_val  = cur;
      end
    end
  end

  // Issue one descriptor, queue up to n_push expected requests in raster
  // order from the hand-computed base/deltas, and wait for them to drain.
  task automatic run_block(input logic [11:0] sx, input logic [11:0] sy,
                           input logic [3:0] w, input logic [3:0] h,
                           input logic [2:0] edx, input logic [2:0] edy,
                           input logic [8:0] bx, input logic [9:0] by,
                           input bit toggle, input int n_push);
    int t;
    int k;
    exp_t e;
    t = 0;
    while (blk_ready_out !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) chk("blk_ready_timeout", {31'd0, blk_ready_out}, 32'd1);
    cline_ready_in = 1'b1;
    blk_valid_in   = 1'b1;
    start_x_in     = sx;
    start_y_in     = sy;
    rf_blk_wdt_in  = w;
    rf_blk_hgt_in  = h;
    @(posedge clk); #1;
    blk_valid_in = 1'b0;
    chk("latency_valid", {31'd0, cline_valid_out}, 32'd1);
    chk("blk_ready_busy", {31'd0, blk_ready_out}, 32'd0);
    chk("delta_x", {29'd0, delta_x_out}, {29'd0, edx});
    chk("delta_y", {29'd0, delta_y_out}, {29'd0, edy});
    k = 0;
    for (int yy = 0; yy <= int'(edy); yy++) begin
      for (int xx = 0; xx <= int'(edx); xx++) begin
        if (k < n_push) begin
          e.x     = bx + 9'(xx);
          e.y     = by + 10'(yy);
          e.first = (xx == 0) && (yy == 0);
          e.last  = (xx == int'(edx)) && (yy == int'(edy));
          q.push_back(e);
        end
        k++;
      end
    end
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
      if (q.size() != 0 && toggle) cline_ready_in = ~cline_ready_in;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    cline_ready_in = 1'b1;
  endtask

  initial begin
    reset          = 1'b1;
    blk_valid_in   = 1'b0;
    start_x_in     = '0;
    start_y_in     = '0;
    rf_blk_wdt_in  = '0;
    rf_blk_hgt_in  = '0;
    cline_ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_blk_ready", {31'd0, blk_ready_out},   32'd1);
    chk("rst_valid",     {31'd0, cline_valid_out}, 32'd0);
    chk("rst_first",     {31'd0, cline_first_out}, 32'd0);
    chk("rst_last",      {31'd0, cline_last_out},  32'd0);
    chk("rst_x",         {23'd0, cline_x_out},     32'd0);
    chk("rst_y",         {22'd0, cline_y_out},     32'd0);
    chk("rst_dx",        {29'd0, delta_x_out},     32'd0);
    chk("rst_dy",        {29'd0, delta_y_out},     32'd0);

    // 2x2 lines, ready held high
    run_block(12'd6, 12'd3, 4'd3, 4'd1, 3'd1, 3'd1, 9'd0, 10'd0, 1'b0, 4);
    // single line, both flags, ready back next cycle
    run_block(12'd16, 12'd8, 4'd7, 4'd3, 3'd0, 3'd0, 9'd2, 10'd2, 1'b0, 1);
    chk("single_ready_next", {31'd0, blk_ready_out},   32'd1);
    chk("single_valid_next", {31'd0, cline_valid_out}, 32'd0);
    // 3x5 lines with ready toggling
    run_block(12'd5, 12'd1, 4'd15, 4'd15, 3'd2, 3'd4, 9'd0, 10'd0, 1'b1, 15);
`ifdef CLINE_STAT_EN
    chk("stat_blk",   stat_blk_cnt_out,   32'd3);
    chk("stat_cline", stat_cline_cnt_out, 32'd20);
`endif
    // x line index wraps 511 -> 0
    run_block(12'd4094, 12'd0, 4'd3, 4'd0, 3'd1, 3'd0, 9'd511, 10'd0, 1'b0, 2);

    // abort after two of four handshakes
    run_block(12'd6, 12'd3, 4'd3, 4'd1, 3'd1, 3'd1, 9'd0, 10'd0, 1'b0, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_valid", {31'd0, cline_valid_out}, 32'd0);
    chk("abort_ready", {31'd0, blk_ready_out},   32'd1);
    chk("abort_first", {31'd0, cline_first_out}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_idle_valid", {31'd0, cline_valid_out}, 32'd0);
    end
    run_block(12'd6, 12'd3, 4'd3, 4'd1, 3'd1, 3'd1, 9'd0, 10'd0, 1'b0, 4);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
